fpu_ss_issue_ctrl: RTL and testbench

Issue sequencer and register scoreboard for the FPU subsystem, sitting between the offload stream FIFO pop side and the fpnew / cmem / FP register file datapath. It allows up to MAX_INFLIGHT pipelined fpnew operations plus one memory operation in flight. It stalls instructions on RAW/WAW hazards against pending FP register writes. It arbitrates the single FP register file write port between fpnew results and load responses.

---
 rtl/fpu_ss_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_fpu_ss_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_issue_ctrl.sv
// fpu_ss_issue_ctrl: issue sequencer and FP register scoreboard for the FPU subsystem.
// Pops instructions from the offload FIFO head and issues them to fpnew (up to MAX_INFLIGHT
// pipelined ops) or to the cmem port (one op at a time). RAW/WAW hazards against pending FP
// register writes stall the head. Arbitrates the single FP register file write port, giving
// load responses priority over fpnew results.
// Ports:
//   pop_*        FIFO head handshake and decoded instruction fields (rs*, rd, type flags)
//   fpu_in_*     fpnew issue handshake, fpu_tag_o = {rd_is_fp_i, rd_i}
//   fpu_out_*    fpnew result handshake with returned tag
//   cmem_q/p_*   memory request / response handshakes
//   c_p_*        integer result response to the core
//   fpr_*        FP register file write port control
//   busy_o       any operation outstanding
module fpu_ss_issue_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pop_valid_i,
  output logic       pop_ready_o,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rs3_i,
  input  logic [2:0] rs_used_i,
  input  logic [4:0] rd_i,
  input  logic       rd_is_fp_i,
  input  logic       use_fpu_i,
  input  logic       is_load_i,
  input  logic       is_store_i,
  output logic       fpu_in_valid_o,
  input  logic       fpu_in_ready_i,
  output logic [5:0] fpu_tag_o,
  input  logic       fpu_out_valid_i,
  output logic       fpu_out_ready_o,
  input  logic [5:0] fpu_tag_i,
  output logic       cmem_q_valid_o,
  input  logic       cmem_q_ready_i,
  input  logic       cmem_p_valid_i,
  output logic       cmem_p_ready_o,
  output logic       c_p_valid_o,
  input  logic       c_p_ready_i,
  output logic       fpr_we_o,
  output logic [4:0] fpr_waddr_o,
  output logic       fpr_wsel_o,
  output logic       busy_o
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {MemIdle, MemReq, MemRsp} mem_state_e;

  logic [31:0]     sb_q, sb_d;
  logic [CntW-1:0] inflight_q;
  mem_state_e      mem_q;
  logic [4:0]      ld_rd_q;
  logic            ld_is_load_q;
  logic            int_pend_q;   // integer-result fpnew op outstanding

  logic [2:0] src_busy;
  logic       hazard, is_mem, fpu_can_issue;
  logic       fpu_in_hs, fpu_out_hs, mem_req_hs, ld_wr, fpu_wr;

  // Hazard is evaluated against the registered scoreboard only, so a same-cycle clear
  // never lets a dependent instruction through.
  assign src_busy = {sb_q[rs3_i], sb_q[rs2_i], sb_q[rs1_i]};
  assign hazard   = (|(rs_used_i & src_busy)) | (rd_is_fp_i & sb_q[rd_i]);
  assign is_mem   = (is_load_i | is_store_i) & ~use_fpu_i;

  // Integer-result ops wait for an empty pipe so their results stay in order.
  assign fpu_can_issue = use_fpu_i & ~hazard & ~int_pend_q &
                         (rd_is_fp_i ? (inflight_q < CntW'(MAX_INFLIGHT)) : (inflight_q == '0));

  assign fpu_in_valid_o = pop_valid_i & fpu_can_issue;
  assign fpu_tag_o      = {rd_is_fp_i, rd_i};
  assign fpu_in_hs      = fpu_in_valid_o & fpu_in_ready_i;

  assign cmem_q_valid_o = (mem_q == MemReq);
  assign mem_req_hs     = cmem_q_valid_o & cmem_q_ready_i;
  assign cmem_p_ready_o = (mem_q == MemRsp);

  assign pop_ready_o = pop_valid_i & (fpu_in_hs | mem_req_hs);

  // Writeback arbitration: a load response always wins the write port.
  assign ld_wr  = (mem_q == MemRsp) & ld_is_load_q & cmem_p_valid_i;
  assign fpu_wr = fpu_out_valid_i & fpu_tag_i[5] & ~ld_wr;

  assign fpu_out_ready_o = fpu_out_valid_i & (fpu_tag_i[5] ? ~ld_wr : c_p_ready_i);
  assign c_p_valid_o     = fpu_out_valid_i & ~fpu_tag_i[5];
  assign fpu_out_hs      = fpu_out_valid_i & fpu_out_ready_o;

  assign fpr_we_o    = ld_wr | fpu_wr;
  assign fpr_wsel_o  = ld_wr;
  assign fpr_waddr_o = ld_wr ? ld_rd_q : (fpu_wr ? fpu_tag_i[4:0] : 5'd0);

  assign busy_o = (sb_q != '0) | (inflight_q != '0) | (mem_q != MemIdle);

  always_comb begin
    sb_d = sb_q;
    if (ld_wr)                    sb_d[ld_rd_q]        = 1'b0;
    if (fpu_wr)                   sb_d[fpu_tag_i[4:0]] = 1'b0;
    if (fpu_in_hs && rd_is_fp_i)  sb_d[rd_i]           = 1'b1;
    if (mem_req_hs && is_load_i)  sb_d[rd_i]           = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q         <= '0;
      inflight_q   <= '0;
      mem_q        <= MemIdle;
      ld_rd_q      <= '0;
      ld_is_load_q <= 1'b0;
      int_pend_q   <= 1'b0;
    end else begin
      sb_q <= sb_d;

      if (fpu_in_hs && !fpu_out_hs && inflight_q != '1) begin
        inflight_q <= inflight_q + CntW'(1);
      end else if (!fpu_in_hs && fpu_out_hs && inflight_q != '0) begin
        inflight_q <= inflight_q - CntW'(1);
      end

      if (fpu_in_hs && !rd_is_fp_i) begin
        int_pend_q <= 1'b1;
      end else if (fpu_out_hs && !fpu_tag_i[5]) begin
        int_pend_q <= 1'b0;
      end

      case (mem_q)
        MemIdle: if (pop_valid_i && is_mem && !hazard) mem_q <= MemReq;
        MemReq: begin
          if (cmem_q_ready_i) begin
            mem_q        <= MemRsp;
            ld_is_load_q <= is_load_i;
            if (is_load_i) ld_rd_q <= rd_i;
          end
        end
        MemRsp:  if (cmem_p_valid_i) mem_q <= MemIdle;
        default: mem_q <= MemIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_ss_issue_ctrl.sv
module tb_fpu_ss_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pop_valid, pop_ready;
  logic [4:0] rs1, rs2, rs3, rd;
  logic [2:0] rs_used;
  logic       rd_is_fp, use_fpu, is_load, is_store;
  logic       fpu_in_valid, fpu_in_ready;
  logic [5:0] fpu_tag_out, fpu_tag_in;
  logic       fpu_out_valid, fpu_out_ready;
  logic       cmem_q_valid, cmem_q_ready, cmem_p_valid, cmem_p_ready;
  logic       c_p_valid, c_p_ready;
  logic       fpr_we, fpr_wsel, busy;
  logic [4:0] fpr_waddr;
  logic [20:0] outs;

  int total = 0;
  int bad   = 0;

  fpu_ss_issue_ctrl #(.MAX_INFLIGHT(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pop_valid_i    (pop_valid),
    .pop_ready_o    (pop_ready),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .rs3_i          (rs3),
    .rs_used_i      (rs_used),
    .rd_i           (rd),
    .rd_is_fp_i     (rd_is_fp),
    .use_fpu_i      (use_fpu),
    .is_load_i      (is_load),
    .is_store_i     (is_store),
    .fpu_in_valid_o (fpu_in_valid),
    .fpu_in_ready_i (fpu_in_ready),
    .fpu_tag_o      (fpu_tag_out),
    .fpu_out_valid_i(fpu_out_valid),
    .fpu_out_ready_o(fpu_out_ready),
    .fpu_tag_i      (fpu_tag_in),
    .cmem_q_valid_o (cmem_q_valid),
    .cmem_q_ready_i (cmem_q_ready),
    .cmem_p_valid_i (cmem_p_valid),
    .cmem_p_ready_o (cmem_p_ready),
    .c_p_valid_o    (c_p_valid),
    .c_p_ready_i    (c_p_ready),
    .fpr_we_o       (fpr_we),
    .fpr_waddr_o    (fpr_waddr),
    .fpr_wsel_o     (fpr_wsel),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  assign outs = {pop_ready, fpu_in_valid, fpu_tag_out, fpu_out_ready, cmem_q_valid,
                 cmem_p_ready, c_p_valid, fpr_we, fpr_waddr, fpr_wsel, busy};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic head_idle();
    pop_valid = 0; use_fpu = 0; rd_is_fp = 0; rd = 0; rs_used = 0;
    rs1 = 0; rs2 = 0; rs3 = 0; is_load = 0; is_store = 0;
  endtask

  task automatic head(input logic fpu, input logic fp, input logic [4:0] d,
                      input logic [2:0] used, input logic [4:0] s1,
                      input logic ld, input logic st);
    pop_valid = 1; use_fpu = fpu; rd_is_fp = fp; rd = d; rs_used = used;
    rs1 = s1; rs2 = 0; rs3 = 0; is_load = ld; is_store = st;
  endtask

  initial begin
    rst_n = 0;
    head_idle();
    fpu_in_ready = 0; fpu_out_valid = 0; fpu_tag_in = 0;
    cmem_q_ready = 0; cmem_p_valid = 0; c_p_ready = 0;
    #12;
    chk("reset_outs", 32'(outs), 0);
    rst_n = 1;
    tick();

    // Back-to-back independent fadds to f1, f2
    fpu_in_ready = 1;
    head(1, 1, 5'd1, 3'b000, 5'd0, 0, 0);
    settle();
    chk("b2b_valid0", 32'(fpu_in_valid), 1);
    chk("b2b_pop0", 32'(pop_ready), 1);
    chk("b2b_tag0", 32'(fpu_tag_out), 32'h21);
    tick();
    rd = 5'd2;
    settle();
    chk("b2b_valid1", 32'(fpu_in_valid), 1);
    chk("b2b_tag1", 32'(fpu_tag_out), 32'h22);
    tick();
    head_idle();
    settle();
    chk("b2b_inflight", 32'(dut.inflight_q), 2);
    chk("b2b_sb", dut.sb_q, 32'h6);
    chk("b2b_busy", 32'(busy), 1);
    fpu_out_valid = 1; fpu_tag_in = 6'h21;
    settle();
    chk("b2b_wr1", {29'd0, fpr_we, fpr_wsel, fpu_out_ready}, 32'b101);
    chk("b2b_waddr1", 32'(fpr_waddr), 1);
    tick();
    fpu_tag_in = 6'h22;
    settle();
    chk("b2b_waddr2", 32'(fpr_waddr), 2);
    tick();
    fpu_out_valid = 0;
    settle();
    chk("b2b_sb_clr", dut.sb_q, 0);
    chk("b2b_idle", 32'(busy), 0);

    // RAW stall on f3
    head(1, 1, 5'd3, 3'b000, 5'd0, 0, 0);
    tick();
    head(1, 1, 5'd6, 3'b001, 5'd3, 0, 0);
    settle();
    chk("raw_stall0", {30'd0, fpu_in_valid, pop_ready}, 0);
    tick();
    fpu_out_valid = 1; fpu_tag_in = 6'h23;
    settle();
    chk("raw_wr_f3", {27'd0, fpr_we, fpr_waddr}, {27'd0, 1'b1, 5'd3});
    chk("raw_stall_clr_cycle", 32'(fpu_in_valid), 0);
    tick();
    fpu_out_valid = 0;
    settle();
    chk("raw_issue", 32'(fpu_in_valid), 1);
    chk("raw_tag", 32'(fpu_tag_out), 32'h26);
    tick();
    head_idle();
    fpu_out_valid = 1; fpu_tag_in = 6'h26;
    tick();
    fpu_out_valid = 0;
    settle();
    chk("raw_drained", dut.sb_q, 0);

    // Inflight cap at 4
    for (int i = 1; i <= 4; i++) begin
      head(1, 1, 5'(i), 3'b000, 5'd0, 0, 0);
      settle();
      chk($sformatf("cap_issue%0d", i), 32'(fpu_in_valid), 1);
      tick();
    end
    head(1, 1, 5'd5, 3'b000, 5'd0, 0, 0);
    settle();
    chk("cap_block0", 32'(fpu_in_valid), 0);
    tick();
    fpu_out_valid = 1; fpu_tag_in = 6'h21;
    settle();
    chk("cap_block_ret", 32'(fpu_in_valid), 0);
    chk("cap_ret_ready", 32'(fpu_out_ready), 1);
    tick();
    fpu_out_valid = 0;
    settle();
    chk("cap_fifth", 32'(fpu_in_valid), 1);
    tick();
    head_idle();
    settle();
    chk("cap_inflight", 32'(dut.inflight_q), 4);
    chk("cap_sb", dut.sb_q, 32'h3C);
    fpu_out_valid = 1;
    for (int i = 2; i <= 5; i++) begin
      fpu_tag_in = {1'b1, 5'(i)};
      tick();
    end
    fpu_out_valid = 0;
    settle();
    chk("cap_drained", 32'(dut.inflight_q), 0);

    // Writeback collision: fadd f5 in flight, then load f4
    head(1, 1, 5'd5, 3'b000, 5'd0, 0, 0);
    tick();
    head(0, 1, 5'd4, 3'b000, 5'd0, 1, 0);
    settle();
    chk("ld_idle", {30'd0, cmem_q_valid, pop_ready}, 0);
    tick();
    cmem_q_ready = 1;
    settle();
    chk("ld_req", {30'd0, cmem_q_valid, pop_ready}, 32'b11);
    tick();
    head_idle();
    cmem_q_ready = 0;
    settle();
    chk("ld_rsp_sb", dut.sb_q, 32'h30);
    chk("ld_rsp_ready", 32'(cmem_p_ready), 1);
    cmem_p_valid = 1; fpu_out_valid = 1; fpu_tag_in = 6'h25;
    settle();
    chk("col_n", {fpr_we, fpr_waddr, fpr_wsel, fpu_out_ready}, {1'b1, 5'd4, 1'b1, 1'b0});
    tick();
    cmem_p_valid = 0;
    settle();
    chk("col_n1", {fpr_we, fpr_waddr, fpr_wsel, fpu_out_ready}, {1'b1, 5'd5, 1'b0, 1'b1});
    tick();
    fpu_out_valid = 0;
    settle();
    chk("col_done", {31'd0, busy}, 0);

    // Store waits for response, produces no write
    head(0, 0, 5'd0, 3'b010, 5'd0, 0, 1);
    tick();
    cmem_q_ready = 1;
    tick();
    head_idle();
    cmem_q_ready = 0;
    cmem_p_valid = 1;
    settle();
    chk("st_rsp", {30'd0, cmem_p_ready, fpr_we}, 32'b10);
    tick();
    cmem_p_valid = 0;
    settle();
    chk("st_done", {31'd0, busy}, 0);

    // Neither FPU nor memory op is never popped
    head(0, 0, 5'd9, 3'b000, 5'd0, 0, 0);
    settle();
    chk("nop_no_pop", 32'(pop_ready), 0);
    tick();
    head_idle();

    // Integer result (feq.s to x10)
    head(1, 0, 5'd10, 3'b000, 5'd0, 0, 0);
    settle();
    chk("int_issue", {25'd0, fpu_in_valid, fpu_tag_out}, {25'd0, 1'b1, 6'h0A});
    tick();
    fpu_in_ready = 0;
    head(1, 1, 5'd7, 3'b000, 5'd0, 0, 0);
    fpu_out_valid = 1; fpu_tag_in = 6'h0A;
    settle();
    chk("int_wait", {28'd0, c_p_valid, fpu_out_ready, fpr_we, fpu_in_valid}, 32'b1000);
    tick();
    settle();
    chk("int_held", 32'(c_p_valid), 1);
    c_p_ready = 1;
    settle();
    chk("int_accept", {29'd0, fpu_out_ready, fpr_we, fpu_in_valid}, 32'b100);
    tick();
    fpu_out_valid = 0; c_p_ready = 0;
    settle();
    chk("int_after", {30'd0, fpu_in_valid, pop_ready}, 32'b10);
    head_idle();
    fpu_in_ready = 1;
    settle();
    chk("int_idle", {31'd0, busy}, 0);

    // Reset while in MEM_RSP with sb = 0x10
    head(0, 1, 5'd4, 3'b000, 5'd0, 1, 0);
    tick();
    cmem_q_ready = 1;
    tick();
    head_idle();
    cmem_q_ready = 0;
    settle();
    chk("rst_pre_sb", dut.sb_q, 32'h10);
    chk("rst_pre_busy", {30'd0, busy, cmem_p_ready}, 32'b11);
    rst_n = 0;
    #1;
    chk("rst_mid_outs", 32'(outs), 0);
    tick();
    chk("rst_low_busy", {31'd0, busy}, 0);
    rst_n = 1;
    tick();
    settle();
    chk("rst_after_outs", 32'(outs), 0);
    chk("rst_after_sb", dut.sb_q, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
